// File: rtl/sha256_stream_core.sv
// Multi-block SHA-256 compression core with an internal chaining register and
// valid/ready block input and digest output; ROUNDS_PER_CYCLE rounds per clock.
module sha256_stream_core #(
    parameter int unsigned ROUNDS_PER_CYCLE = 1,
    parameter bit          LOAD_IV_ON_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] H_in,
    input  logic [511:0] M_in,
    input  logic         in_first,
    input  logic         in_last,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [255:0] H_out,
    output logic         out_valid,
    input  logic         out_ready
);

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
        ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : g_bad_rounds
        $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [6:0] RSTEP = 7'(ROUNDS_PER_CYCLE);

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    typedef enum logic [1:0] {StIdle, StRound, StFinal, StOut} state_e;

    state_e       state_q;
    logic [5:0]   cnt_q;
    logic         last_q;
    logic [255:0] h_reg_q;
    logic [255:0] chain_src_q;
    logic [31:0]  work_q [8];
    logic [31:0]  work_d [8];
    logic [31:0]  w_q [16];
    logic [31:0]  w_d [16];
    logic [31:0]  t1, t2, new_w;
    logic [255:0] chain_sel;
    logic [255:0] h_new;
    logic         last_round;

    assign in_ready   = (state_q == StIdle) && !rst;
    assign last_round = ({1'b0, cnt_q} + RSTEP) == 7'd64;
    assign chain_sel  = in_first ? (LOAD_IV_ON_FIRST ? IV : H_in) : h_reg_q;

    // Unrolled rounds; w_d[0] is always W[t] for the round being applied.
    always_comb begin
        work_d = work_q;
        w_d    = w_q;
        t1     = '0;
        t2     = '0;
        new_w  = '0;
        for (int j = 0; j < int'(ROUNDS_PER_CYCLE); j++) begin
            t1 = work_d[7] + bsig1(work_d[4]) + ((work_d[4] & work_d[5]) ^ (~work_d[4] & work_d[6]))
                 + K[cnt_q + 6'(j)] + w_d[0];
            t2 = bsig0(work_d[0]) + ((work_d[0] & work_d[1]) ^ (work_d[0] & work_d[2]) ^
                                     (work_d[1] & work_d[2]));
            new_w = ssig1(w_d[14]) + w_d[9] + ssig0(w_d[1]) + w_d[0];
            for (int i = 7; i > 0; i--) work_d[i] = work_d[i-1];
            work_d[4] = work_d[4] + t1;
            work_d[0] = t1 + t2;
            for (int i = 0; i < 15; i++) w_d[i] = w_d[i+1];
            w_d[15] = new_w;
        end
    end

    always_comb begin
        h_new = '0;
        for (int i = 0; i < 8; i++) begin
            h_new[255-32*i -: 32] = chain_src_q[255-32*i -: 32] + work_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            h_reg_q     <= IV;
            chain_src_q <= '0;
            H_out       <= '0;
            out_valid   <= 1'b0;
            for (int i = 0; i < 8; i++) work_q[i] <= '0;
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        last_q      <= in_last;
                        chain_src_q <= chain_sel;
                        cnt_q       <= '0;
                        for (int i = 0; i < 8; i++) work_q[i] <= chain_sel[255-32*i -: 32];
                        for (int i = 0; i < 16; i++) w_q[i] <= M_in[511-32*i -: 32];
                        state_q     <= StRound;
                    end
                end
                StRound: begin
                    work_q <= work_d;
                    w_q    <= w_d;
                    cnt_q  <= cnt_q + RSTEP[5:0];
                    if (last_round) state_q <= StFinal;
                end
                StFinal: begin
                    h_reg_q <= h_new;
                    if (last_q) begin
                        H_out     <= h_new;
                        out_valid <= 1'b1;
                        state_q   <= StOut;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StOut: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
